// File: rtl/special_seq_counter.sv
// special_seq_counter: steps an index through a writable table of values,
// presenting the table entry at the current index on a registered output.
// The sequence length is programmable and a one-cycle pulse marks each wrap.
module special_seq_counter #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             len_we,
    input  logic [AW-1:0]    len_val,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    idx,
    output logic             tc
);

    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [AW-1:0]    last_q, last_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             wr_hit;

    // Next-state: a length update overrides stepping; otherwise step with wrap.
    always_comb begin
        last_d = last_q;
        idx_d  = idx_q;
        tc_d   = 1'b0;
        wr_hit = wr_en && (int'(wr_addr) < DEPTH);
        if (len_we) begin
            last_d = (int'(len_val) > DEPTH - 1) ? AW'(DEPTH - 1) : len_val;
            // An index beyond the shrunk sequence restarts at the first entry.
            idx_d  = (idx_q > last_d) ? '0 : idx_q;
        end else if (en) begin
            if (dir) begin
                if (idx_q == last_q) begin
                    idx_d = '0;
                    tc_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d = last_q;
                    tc_d  = 1'b1;
                end else begin
                    idx_d = idx_q - AW'(1);
                end
            end
        end
        // q tracks the entry at the next index; a same-edge write to it wins.
        q_d = (wr_hit && (wr_addr == idx_d)) ? wr_data : tbl_q[idx_d];
    end

    // Counter, output and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= AW'(DEPTH - 1);
            idx_q  <= '0;
            q_q    <= '0;
            tc_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            idx_q  <= idx_d;
            q_q    <= q_d;
            tc_q   <= tc_d;
        end
    end

    // Sequence table; reset loads the identity sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= WIDTH'(i);
        end else if (wr_hit) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    assign q   = q_q;
    assign idx = idx_q;
    assign tc  = tc_q;

endmodule

// File: doc/special_seq_counter.md
SPECIAL_SEQ_COUNTER -- requirements
Module: special_seq_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: width in bits of each sequence value and of q.
REQ-002 SHALL have parameter DEPTH, default 8: number of sequence-table entries; legal range 2..256.
REQ-003 SHALL derive localparam AW = clog2(DEPTH) as the index width.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  step enable.
REQ-007 SHALL have port dir  input  1  step direction: 1 = up, 0 = down.
REQ-008 SHALL have port wr_en  input  1  sequence-table write strobe.
REQ-009 SHALL have port wr_addr  input  AW  table entry to write.
REQ-010 SHALL have port wr_data  input  WIDTH  value to write.
REQ-011 SHALL have port len_we  input  1  sequence-length update strobe.
REQ-012 SHALL have port len_val  input  AW  new last index (sequence length minus 1).
REQ-013 SHALL have port q  output  WIDTH  registered current sequence value.
REQ-014 SHALL have port idx  output  AW  registered current table index.
REQ-015 SHALL have port tc  output  1  registered one-cycle wrap pulse.

Function
REQ-016 SHALL hold a DEPTH x WIDTH table of flops plus an AW-bit last-index register.
REQ-017 SHALL update all state on the rising edge of clk only, except for reset.
REQ-018 SHALL step idx, when en=1, len_we=0 and dir=1, as follows: idx == last -> 0, otherwise idx+1.
REQ-019 SHALL step idx, when en=1, len_we=0 and dir=0, as follows: idx == 0 -> last, otherwise idx-1.
REQ-020 SHALL hold idx unchanged when en=0.
REQ-021 SHALL keep q == table[idx] as a registered value, with q loaded from table[idx_next] on the same edge that idx updates.
REQ-022 SHALL give a same-cycle write precedence on read: if wr_en=1 and wr_addr == idx_next, q SHALL load wr_data.
REQ-023 SHALL, when wr_en=1 and wr_addr < DEPTH, write table[wr_addr] <= wr_data.
REQ-024 SHALL ignore writes with wr_addr >= DEPTH, with no state change.
REQ-025 SHALL assert tc for exactly the cycle following an edge on which idx wrapped (last->0 when counting up, 0->last when counting down); tc SHALL be 0 otherwise.
REQ-026 SHALL, when len_we=1, set last <= min(len_val, DEPTH-1).
REQ-027 SHALL suppress any count step on a len_we cycle regardless of en.
REQ-028 SHALL, on a len_we cycle, set idx_next = 0 if current idx > the new last, otherwise hold idx; q SHALL follow REQ-021/022 and tc SHALL be 0.
REQ-029 SHALL, with last == 0, keep idx at 0 and pulse tc on every enabled step.
REQ-030 SHALL set latency from en to a q change at exactly one clock edge.

Reset
REQ-031 SHALL, while rst_n=0, immediately set idx=0, q=0, tc=0, last=DEPTH-1, and table[i] = i mod 2^WIDTH for every i.
REQ-032 SHALL take no step on the first rising edge after rst_n deasserts unless en=1 at that edge.

Verification
REQ-033 SHALL verify reset and default count: after reset, drive en=1, dir=1 for 8 clks -> q = 1,2,3,4,5,6,7,0, with tc=1 only in the cycle after the 7->0 step.
REQ-034 SHALL verify a programmed sequence: write table 0,1,3,2,6,7,5,4 (Gray code), then count up -> q follows that order and wraps to 0 with a tc pulse.
REQ-035 SHALL verify down wrap: from idx=0 drive en=1, dir=0 -> idx=7, q=table[7], tc=1 for one cycle.
REQ-036 SHALL verify a length shrink mid-count: at idx=6 drive len_we=1, len_val=4 -> idx=0, q=table[0], no tc; subsequent up-count gives idx 1,2,3,4,0 with tc on the wrap.
REQ-037 SHALL verify write collision: at idx=2 with en=1, dir=1, wr_en=1, wr_addr=3, wr_data=5 -> next cycle idx=3, q=5, and table[3]=5 thereafter.
REQ-038 SHALL verify asynchronous reset mid-count: pull rst_n low between clock edges -> q=0, idx=0, tc=0 without waiting for a clock edge, and the table returns to identity.
